spi_xfer_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one SPI master transfer engine among NUM_REQ requesters.

---
 rtl/spi_xfer_arbiter.sv | 147 ++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI transfer engine among NUM_REQ requesters.
// Define SPI_XFER_TIMEOUT_EN to add a WAIT-state watchdog that drives err_o.
module spi_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      enable_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  input  logic                      tip_i,
  input  logic                      xfer_done_i,
  input  logic [DATA_W-1:0]         spi_rx_i,
  output logic                      send_data_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rx_data_o,
  output logic                      busy_o,
  output logic                      err_o
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;
  localparam logic [SW-1:0] NR = SW'(NUM_REQ);

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d, win_q, win_d, pick;
  logic [SW-1:0]       sum, nxt;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d;
  logic                send_q, send_d, busy_q, busy_d, err_q, err_d;
`ifdef SPI_XFER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]       cnt_q, cnt_d;
`else
  logic                unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    send_d  = 1'b0;
    done_d  = '0;
    err_d   = 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    // Scan downwards so the last hit is the first set request at or after ptr.
    pick = ptr_q;
    sum  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + SW'(i);
      sum = (sum >= NR) ? sum - NR : sum;
      if (req_i[sum[PW-1:0]]) pick = sum[PW-1:0];
    end
    nxt = {1'b0, win_q} + SW'(1);
    nxt = (nxt >= NR) ? '0 : nxt;
    case (state_q)
      IDLE: if (enable_i && |req_i && !tip_i) begin
        state_d = LAUNCH;
        win_d   = pick;
        gnt_d   = NUM_REQ'(1) << pick;
        tx_d    = data_i[pick*DATA_W +: DATA_W];
        send_d  = 1'b1;
      end
      LAUNCH: begin
        state_d = enable_i ? WAIT : IDLE;
`ifdef SPI_XFER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: if (!enable_i) state_d = IDLE;
      else if (xfer_done_i) begin
        state_d = DONE;
        rx_d    = spi_rx_i;
        done_d  = gnt_q;
      end
`ifdef SPI_XFER_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        ptr_d   = nxt[PW-1:0];
      end
      else cnt_d = cnt_q + CW'(1);
`endif
      DONE: begin
        state_d = IDLE;
        ptr_d   = nxt[PW-1:0];
      end
      default: state_d = IDLE;
    endcase
    // Grant and TX word are only meaningful while a transaction is open.
    if (state_d == IDLE) begin
      gnt_d = '0;
      tx_d  = '0;
    end
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      send_q  <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      send_q  <= send_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef SPI_XFER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign send_data_o = send_q;
  assign tx_data_o   = tx_q;
  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rx_data_o   = rx_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed vectors for spi_xfer_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT_CYCLES=16).
module tb_spi_xfer_arbiter;
  logic        PCLK = 1'b0, PRESET = 1'b1, enable_i = 1'b1, tip_i = 1'b0, xfer_done_i = 1'b0;
  logic [3:0]  req_i = '0;
  logic [31:0] data_i = {8'h7E, 8'hC3, 8'hA5, 8'h11};
  logic [7:0]  spi_rx_i = '0;
  logic        send_data_o, busy_o, err_o;
  logic [7:0]  tx_data_o, rx_data_o;
  logic [3:0]  gnt_o, done_o;
  int          n_vec = 0, n_err = 0;

  spi_xfer_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .enable_i(enable_i), .req_i(req_i), .data_i(data_i),
    .tip_i(tip_i), .xfer_done_i(xfer_done_i), .spi_rx_i(spi_rx_i), .send_data_o(send_data_o),
    .tx_data_o(tx_data_o), .gnt_o(gnt_o), .done_o(done_o), .rx_data_o(rx_data_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    tick; tick;
    chk("rst_gnt", gnt_o, 0); chk("rst_send", send_data_o, 0); chk("rst_done", done_o, 0);
    chk("rst_rx", rx_data_o, 0); chk("rst_busy", busy_o, 0); chk("rst_err", err_o, 0);
    chk("rst_tx", tx_data_o, 0);
    PRESET = 1'b0;
    // single transfer from requester 1
    req_i = 4'b0010;
    tick;
    chk("t2_gnt", gnt_o, 4'b0010); chk("t2_send", send_data_o, 1);
    chk("t2_tx", tx_data_o, 8'hA5); chk("t2_busy", busy_o, 1);
    tick;
    chk("t2_send_off", send_data_o, 0); chk("t2_gnt_wait", gnt_o, 4'b0010);
    tick;
    xfer_done_i = 1'b1; spi_rx_i = 8'h3C;
    tick;
    chk("t2_done", done_o, 4'b0010); chk("t2_rx", rx_data_o, 8'h3C); chk("t2_gnt_done", gnt_o, 4'b0010);
    xfer_done_i = 1'b0; req_i = '0;
    tick;
    chk("t2_gnt_idle", gnt_o, 0); chk("t2_done_off", done_o, 0); chk("t2_busy_idle", busy_o, 0);
    chk("t2_tx_idle", tx_data_o, 0); chk("t2_rx_hold", rx_data_o, 8'h3C);
    // reset mid-WAIT; ptr is 2 so requester 3 wins first
    req_i = 4'b1000;
    tick;
    chk("t1_gnt", gnt_o, 4'b1000);
    tick;
    PRESET = 1'b1;
    tick;
    chk("t1_gnt", gnt_o, 0); chk("t1_busy", busy_o, 0); chk("t1_rx", rx_data_o, 0);
    chk("t1_tx", tx_data_o, 0); chk("t1_done", done_o, 0);
    PRESET = 1'b0;
    // fairness with all requesting: 0,1,2,3,0
    req_i = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick;
      chk("t3_gnt", gnt_o, 32'd1 << (j % 4)); chk("t3_send", send_data_o, 1);
      chk("t3_tx", tx_data_o, (data_i >> (8 * (j % 4))) & 32'hFF);
      tick;
      xfer_done_i = 1'b1; spi_rx_i = 8'h40 + 8'(j);
      tick;
      chk("t3_done", done_o, 32'd1 << (j % 4)); chk("t3_rx", rx_data_o, 32'h40 + j);
      xfer_done_i = 1'b0;
      if (j == 4) req_i = '0;
      tick;
      chk("t3_idle_gnt", gnt_o, 0); chk("t3_idle_busy", busy_o, 0);
    end
    // abort by enable_i in WAIT; ptr is 1
    req_i = 4'b0100;
    tick;
    chk("t4_gnt", gnt_o, 4'b0100);
    tick;
    enable_i = 1'b0;
    tick;
    chk("t4_abort_gnt", gnt_o, 0); chk("t4_abort_done", done_o, 0);
    chk("t4_abort_busy", busy_o, 0); chk("t4_rx_hold", rx_data_o, 8'h44);
    tick;
    chk("t4_dis_gnt", gnt_o, 0);
    enable_i = 1'b1;
    tick;
    chk("t4_regnt", gnt_o, 4'b0100); chk("t4_send", send_data_o, 1); chk("t4_tx", tx_data_o, 8'hC3);
    xfer_done_i = 1'b1; spi_rx_i = 8'hEE;
    tick;
    chk("t4_launch_ign_done", done_o, 0); chk("t4_launch_ign_rx", rx_data_o, 8'h44);
    spi_rx_i = 8'h5A;
    tick;
    chk("t4_done", done_o, 4'b0100); chk("t4_rx", rx_data_o, 8'h5A);
    xfer_done_i = 1'b0; req_i = '0;
    tick;
    // tip_i blocks launch; ptr is 3 so requester 0 wins
    tip_i = 1'b1; req_i = 4'b0001;
    for (int j = 0; j < 10; j++) begin
      tick;
      chk("t5_tip_send", send_data_o, 0);
    end
    tip_i = 1'b0;
    tick;
    chk("t5_send", send_data_o, 1); chk("t5_gnt", gnt_o, 4'b0001);
    tick;
    tip_i = 1'b1; xfer_done_i = 1'b1; spi_rx_i = 8'h99;
    tick;
    chk("t5_done", done_o, 4'b0001); chk("t5_rx", rx_data_o, 8'h99);
    tip_i = 1'b0; xfer_done_i = 1'b0; req_i = '0;
    tick;
    // watchdog; ptr is 1
    req_i = 4'b0010;
    tick;
    chk("t6_gnt", gnt_o, 4'b0010);
    tick;
`ifdef SPI_XFER_TIMEOUT_EN
    for (int j = 0; j < 15; j++) begin
      tick;
      chk("t6_pre_err", err_o, 0);
    end
    chk("t6_pre_gnt", gnt_o, 4'b0010);
    req_i = 4'b0110;
    tick;
    chk("t6_err", err_o, 1); chk("t6_gnt_off", gnt_o, 0); chk("t6_no_done", done_o, 0);
    tick;
    chk("t6_err_pulse", err_o, 0); chk("t6_next_gnt", gnt_o, 4'b0100);
    req_i = '0;
    tick;
`else
    for (int j = 0; j < 40; j++) tick;
    chk("t6_no_err", err_o, 0); chk("t6_still_gnt", gnt_o, 4'b0010); chk("t6_busy", busy_o, 1);
`endif
    xfer_done_i = 1'b1; spi_rx_i = 8'h77;
    tick;
    xfer_done_i = 1'b0; req_i = '0;
    tick; tick;
    chk("end_busy", busy_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
